mem_port_arbiter: RTL and testbench

Sequences a single-ported unified memory between the two pipeline requesters: the instruction-fetch stage (read only) and the memory stage (load/store). It sits between the IF/MEM stages and the shared memory. It grants one transaction at a time, with data given priority over fetch. It produces combinational stall conditions (`req & ~ack`) that feed the hazard unit. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/arb_watchdog.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } arb_owner_e;

  function automatic arb_owner_e state_owner(input arb_state_e st);
    arb_owner_e own;
    case (st)
      D_BUSY:  own = OWN_D;
      I_BUSY:  own = OWN_I;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

  // Watchdog counter width; never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: clears on clr, counts while en, flags expiry on the
// TIMEOUT-th counted cycle. TIMEOUT of 0 removes the counter entirely.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = wd_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, en};
      assign expire    = 1'b0;
    end else begin : g_on
      // Expiry is decoded from the current count so the ack lands in the
      // TIMEOUT-th busy cycle rather than one cycle later.
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire = en & (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage,
// data first, with a watchdog that aborts transactions memory never acks.
//
// state  | meaning
// IDLE   | no transaction, mem_req low, requests arbitrated here
// D_BUSY | data load/store owns the port until completion
// I_BUSY | instruction fetch owns the port until completion
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  arb_state_e    state_q;
  arb_state_e    state_d;
  arb_owner_e    owner;
  logic          busy;
  logic          complete;
  logic          wd_expire;
  logic          grant_d;
  logic          grant_i;

  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q,       err_d;

  assign busy     = (state_q != IDLE);
  assign owner    = state_owner(state_q);
  assign complete = busy & (mem_ack | wd_expire);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (~busy | complete),
    .en     (busy & ~mem_ack),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The owner's own request is not looked at on completion, so a held
  // request always passes through IDLE or yields to the other port.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = D_BUSY;
        end else if (i_req) begin
          state_d = I_BUSY;
        end
      end
      D_BUSY: begin
        if (complete) begin
          state_d = i_req ? I_BUSY : IDLE;
        end
      end
      I_BUSY: begin
        if (complete) begin
          state_d = d_req ? D_BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_d = (state_d == D_BUSY) & (state_q != D_BUSY);
  assign grant_i = (state_d == I_BUSY) & (state_q != I_BUSY);

  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_d) begin
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (grant_i) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = i_addr;
      mem_wdata_d = '0;
    end
    err_d = err_q | wd_expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    mem_req   = busy;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    err       = err_q;
    i_ack     = (owner == OWN_I) & (mem_ack | wd_expire);
    d_ack     = (owner == OWN_D) & (mem_ack | wd_expire);
    i_rdata   = wd_expire ? '0 : mem_rdata;
    d_rdata   = wd_expire ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: port drivers, a latency-configurable
// memory model, and per-cycle history for latency/gap checks.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        mem_ack_model = 1'b0;
  logic        mem_ack_extra = 1'b0;
  logic        mem_ack;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        i_ack, d_ack, mem_req, mem_we, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  assign mem_ack = mem_ack_model | mem_ack_extra;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW (32), .DW (32), .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  item_t i_todo[$], d_todo[$], i_exp[$], d_exp[$];
  int    n_err = 0;
  int    n_chk = 0;
  int    cyc = 0;
  int    i_start = 0, d_start = 0, last_i_ack = 0, last_d_ack = 0;
  int    i_ack_cnt = 0, d_ack_cnt = 0;
  int    i_ack_cycq[$];
  bit    mem_en = 1'b1;
  int    mem_lat = 0;
  int    wcnt = 0;
  bit    mreq_hist[4096];
  bit    mwe_hist[4096];
  bit    err_hist[4096];
  logic [31:0] maddr_hist[4096];
  logic  i_fin = 1'b0, d_fin = 1'b0;
  logic  i_pend = 1'b0, d_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hCAFE_F00D : ((a * 32'h0101_0101) ^ 32'h5A00_0000);
  endfunction

  function automatic int h(input int c);
    return c & 4095;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks the mem_lat-th cycle after a transaction starts.
  always begin
    @(posedge clk);
    #1;
    if (mem_req && mem_en) begin
      if (wcnt == mem_lat) begin
        mem_ack_model = 1'b1;
        mem_rdata     = mem_val(mem_addr);
        wcnt          = 0;
      end else begin
        mem_ack_model = 1'b0;
        mem_rdata     = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      mem_ack_model = 1'b0;
      mem_rdata     = 32'hDEAD_BEEF;
      wcnt          = 0;
    end
  end

  always begin : drv_i
    item_t it;
    @(negedge clk);
    i_fin = i_req & i_ack & ~rst;
    @(posedge clk);
    #1;
    if (i_fin) i_req = 1'b0;
    if (!i_req && i_todo.size() > 0) begin
      it      = i_todo.pop_front();
      i_addr  = it.addr;
      i_req   = 1'b1;
      i_start = cyc;
    end
  end

  always begin : drv_d
    item_t it;
    @(negedge clk);
    d_fin = d_req & d_ack & ~rst;
    @(posedge clk);
    #1;
    if (d_fin) d_req = 1'b0;
    if (!d_req && d_todo.size() > 0) begin
      it      = d_todo.pop_front();
      d_we    = it.we;
      d_addr  = it.addr;
      d_wdata = it.wdata;
      d_req   = 1'b1;
      d_start = cyc;
    end
  end

  always @(negedge clk) begin : mon
    item_t e;
    mreq_hist[h(cyc)]  = mem_req;
    mwe_hist[h(cyc)]   = mem_we;
    err_hist[h(cyc)]   = err;
    maddr_hist[h(cyc)] = mem_addr;
    if (!rst) begin
      assert (!i_pend || i_req) else $error("protocol: i_req dropped before i_ack");
      assert (!d_pend || d_req) else $error("protocol: d_req dropped before d_ack");
      if (i_ack && d_ack) chk("both_acks", 1, 0);
      if (i_ack) begin
        i_ack_cnt++;
        last_i_ack = cyc;
        i_ack_cycq.push_back(cyc);
        if (i_exp.size() == 0) begin
          chk("i_ack_unexpected", 1, 0);
        end else begin
          e = i_exp.pop_front();
          chk("i_addr", mem_addr, e.addr);
          chk("i_we", mem_we, 0);
          chk("i_rdata", i_rdata, e.rdata);
        end
      end
      if (d_ack) begin
        d_ack_cnt++;
        last_d_ack = cyc;
        if (d_exp.size() == 0) begin
          chk("d_ack_unexpected", 1, 0);
        end else begin
          e = d_exp.pop_front();
          chk("d_addr", mem_addr, e.addr);
          chk("d_we", mem_we, e.we);
          if (e.we) chk("d_wdata", mem_wdata, e.wdata);
          else      chk("d_rdata", d_rdata, e.rdata);
        end
      end
    end
    i_pend = i_req & ~i_ack & ~rst;
    d_pend = d_req & ~d_ack & ~rst;
  end

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd);
    item_t it;
    it.we = 1'b0; it.addr = a; it.wdata = '0; it.rdata = rd;
    i_todo.push_back(it);
    i_exp.push_back(it);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd);
    item_t it;
    it.we = we; it.addr = a; it.wdata = wd; it.rdata = rd;
    d_todo.push_back(it);
    d_exp.push_back(it);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((i_exp.size() + d_exp.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({tag, "_drain_timeout"}, 0, 1);
      i_exp.delete(); d_exp.delete(); i_todo.delete(); d_todo.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int s, i0, d0, n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single load, memory acks two cycles after mem_req
    mem_en = 1'b1; mem_lat = 2;
    push_d(1'b0, 32'h10, 32'h0, 32'hCAFE_F00D);
    drain("ld");
    s = d_start;
    chk("ld_idle_c0", mreq_hist[h(s)], 0);
    chk("ld_req_c1", mreq_hist[h(s + 1)], 1);
    chk("ld_addr_c1", maddr_hist[h(s + 1)], 32'h10);
    chk("ld_ack_cycle", last_d_ack - s, 3);
    chk("ld_idle_c4", mreq_hist[h(s + 4)], 0);

    // Simultaneous store and fetch, zero-wait memory
    mem_lat = 0;
    i0 = i_ack_cnt; d0 = d_ack_cnt;
    push_d(1'b1, 32'h20, 32'h55, 32'h0);
    push_i(32'h4, mem_val(32'h4));
    drain("sim");
    s = d_start;
    chk("st_we_c1", mwe_hist[h(s + 1)], 1);
    chk("st_addr_c1", maddr_hist[h(s + 1)], 32'h20);
    chk("st_ack_cycle", last_d_ack - s, 1);
    chk("if_handoff_req", mreq_hist[h(s + 2)], 1);
    chk("if_addr_c2", maddr_hist[h(s + 2)], 32'h4);
    chk("if_ack_cycle", last_i_ack - s, 2);
    chk("sim_d_count", d_ack_cnt - d0, 1);
    chk("sim_i_count", i_ack_cnt - i0, 1);

    // Fetch stream 0,1,2 with i_req held continuously
    i_ack_cycq.delete();
    i0 = i_ack_cnt;
    push_i(32'h0, mem_val(32'h0));
    push_i(32'h1, mem_val(32'h1));
    push_i(32'h2, mem_val(32'h2));
    drain("fs");
    chk("fs_count", i_ack_cnt - i0, 3);
    if (i_ack_cycq.size() == 3) begin
      chk("fs_spacing01", i_ack_cycq[1] - i_ack_cycq[0], 2);
      chk("fs_spacing12", i_ack_cycq[2] - i_ack_cycq[1], 2);
      chk("fs_gap0", mreq_hist[h(i_ack_cycq[0] + 1)], 0);
      chk("fs_gap1", mreq_hist[h(i_ack_cycq[1] + 1)], 0);
    end else begin
      chk("fs_ack_cycles", i_ack_cycq.size(), 3);
    end

    // Timeout on a fetch the memory never acks
    mem_en = 1'b0;
    push_i(32'h33, 32'h0);
    drain("to");
    s = i_start;
    chk("to_ack_cycle", last_i_ack - s, TO);
    chk("to_err_low_before", err_hist[h(s + TO)], 0);
    chk("to_err_set", err_hist[h(s + TO + 1)], 1);
    mem_en = 1'b1; mem_lat = 1;
    push_d(1'b0, 32'h40, 32'h0, mem_val(32'h40));
    drain("to_next");
    chk("to_next_ack_cycle", last_d_ack - d_start, 2);
    chk("to_err_sticky", err, 1);

    // Reset while D_BUSY, then a stray mem_ack in the following cycle
    mem_en = 1'b0;
    d0 = d_ack_cnt;
    push_d(1'b0, 32'h50, 32'h0, mem_val(32'h50));
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rs_busy_seen", mem_req, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; mem_ack_extra = 1'b1;
    @(negedge clk);
    chk("rs_no_dack", d_ack, 0);
    chk("rs_mem_req", mem_req, 0);
    chk("rs_err", err, 0);
    chk("rs_mem_addr", mem_addr, 0);
    mem_en = 1'b1; mem_lat = 0;
    @(posedge clk); #1 mem_ack_extra = 1'b0;
    drain("rs");
    chk("rs_represent_count", d_ack_cnt - d0, 1);

    // Spurious mem_ack while IDLE
    i0 = i_ack_cnt; d0 = d_ack_cnt;
    @(posedge clk); #1 mem_ack_extra = 1'b1;
    @(negedge clk);
    chk("sp_no_iack", i_ack, 0);
    chk("sp_no_dack", d_ack, 0);
    @(posedge clk); #1 mem_ack_extra = 1'b0;
    @(negedge clk);
    chk("sp_err", err, 0);
    chk("sp_mem_req", mem_req, 0);
    chk("sp_ack_counts", (i_ack_cnt - i0) + (d_ack_cnt - d0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
